int_controller: RTL and testbench

- Priority interrupt controller directly upstream of the single-cycle CPU.
- Captures rising edges on 8 external interrupt lines and latches them as pending.
- Masks them, picks the highest-priority pending source, and presents one request plus a vector address to the CPU.
- Tracks acknowledge and end-of-interrupt so only one interrupt is in service at a time (no nesting).

---
 rtl/int_ctrl_pkg.sv | 21 ++
 rtl/int_controller_prio_enc8.sv | 22 ++
 rtl/int_controller.sv | 83 ++++++++
 tb/tb_int_controller.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/int_ctrl_pkg.sv
// Shared types and defaults for the priority interrupt controller.
// Imported by int_controller and its priority encoder.
package int_ctrl_pkg;

    localparam int NUM_IRQ = 8;
    localparam int ID_W    = 3;

    localparam logic [15:0] VECTOR_BASE_DEF = 16'h0100;
    localparam int          STRIDE_LOG2_DEF = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    function automatic logic [NUM_IRQ-1:0] onehot(input logic [ID_W-1:0] id);
        return NUM_IRQ'(1) << id;
    endfunction

endpackage

// File: rtl/int_controller_prio_enc8.sv
// Combinational 8-to-3 priority encoder, highest set index wins.
// valid is low when no request bit is set.
module prio_enc8
    import int_ctrl_pkg::*;
(
    input  logic [NUM_IRQ-1:0] req,
    output logic [ID_W-1:0]    idx,
    output logic               valid
);

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (req[i]) begin
                idx   = ID_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/int_controller.sv
// Edge-capturing, masked, fixed-priority interrupt controller.
// One request in flight at a time, no nesting.
module int_controller
    import int_ctrl_pkg::*;
#(
    parameter logic [15:0] VECTOR_BASE = VECTOR_BASE_DEF,
    parameter int          STRIDE_LOG2 = STRIDE_LOG2_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_in,
    input  logic               int_ack,
    input  logic               int_eoi,
    output logic               int_req,
    output logic [ID_W-1:0]    int_id,
    output logic [15:0]        int_vector,
    output logic [NUM_IRQ-1:0] pending,
    output logic [NUM_IRQ-1:0] in_service
);

    state_t             state;
    logic [NUM_IRQ-1:0] prev_irq;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] clr;
    logic [ID_W-1:0]    enc_idx;
    logic               enc_valid;

    assign rise = irq_in & ~prev_irq;
    assign clr  = (state == REQ && int_ack) ? onehot(int_id) : '0;

    prio_enc8 u_enc (
        .req   (pending & mask),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            prev_irq   <= '1;
            mask       <= '1;
            pending    <= '0;
            in_service <= '0;
            int_req    <= 1'b0;
            int_id     <= '0;
            int_vector <= VECTOR_BASE;
        end else begin
            prev_irq <= irq_in;
            // A rise on the acked bit re-sets it, so that event survives.
            pending  <= (pending & ~clr) | rise;
            if (mask_we) mask <= mask_in;
            unique case (state)
                IDLE: begin
                    if (enc_valid) begin
                        int_id     <= enc_idx;
                        int_vector <= VECTOR_BASE
                                      + (16'(enc_idx) << STRIDE_LOG2);
                        int_req    <= 1'b1;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (int_ack) begin
                        in_service <= onehot(int_id);
                        int_req    <= 1'b0;
                        state      <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (int_eoi) begin
                        in_service <= '0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_int_controller.sv
// Bench for int_controller: directed scenarios with literal checks,
// then random traffic compared each cycle against a behavioural model.
module tb_int_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  irq_in;
    logic        mask_we;
    logic [7:0]  mask_in;
    logic        int_ack;
    logic        int_eoi;
    logic        int_req;
    logic [2:0]  int_id;
    logic [15:0] int_vector;
    logic [7:0]  pending;
    logic [7:0]  in_service;

    int passed = 0;
    int total  = 0;

    int_controller dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .mask_we    (mask_we),
        .mask_in    (mask_in),
        .int_ack    (int_ack),
        .int_eoi    (int_eoi),
        .int_req    (int_req),
        .int_id     (int_id),
        .int_vector (int_vector),
        .pending    (pending),
        .in_service (in_service)
    );

    always #5 clk = ~clk;

    // Behavioural model: "requesting" and "serving" are derived from
    // m_req / m_serv rather than an explicit state variable.
    logic        started = 1'b0;
    logic [7:0]  m_prev, m_mask, m_pend, m_serv;
    logic        m_req;
    logic [2:0]  m_id;
    logic [15:0] m_vec;
    logic [7:0]  m_rise, m_elig, m_clr;

    function automatic int top(input logic [7:0] v);
        for (int i = 7; i >= 0; i--)
            if (v[i]) return i;
        return 0;
    endfunction

    always_comb begin
        m_rise = irq_in & ~m_prev;
        m_elig = m_pend & m_mask;
        m_clr  = 8'h00;
        if (m_req && int_ack) m_clr = 8'd1 << m_id;
    end

    always @(posedge clk) begin
        if (reset) begin
            started <= 1'b1;
            m_prev  <= 8'hFF;
            m_mask  <= 8'hFF;
            m_pend  <= 8'h00;
            m_serv  <= 8'h00;
            m_req   <= 1'b0;
            m_id    <= 3'd0;
            m_vec   <= 16'h0100;
        end else begin
            m_prev <= irq_in;
            m_pend <= (m_pend & ~m_clr) | m_rise;
            if (mask_we) m_mask <= mask_in;
            if (m_req) begin
                if (int_ack) begin
                    m_serv <= m_clr;
                    m_req  <= 1'b0;
                end
            end else if (m_serv != 8'h00) begin
                if (int_eoi) m_serv <= 8'h00;
            end else if (m_elig != 8'h00) begin
                m_req <= 1'b1;
                m_id  <= 3'(top(m_elig));
                m_vec <= 16'h0100 + 16'(top(m_elig) * 4);
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h @%0t",
                      name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("m_req", 16'(int_req), 16'(m_req));
            chk("m_id", 16'(int_id), 16'(m_id));
            chk("m_vec", int_vector, m_vec);
            chk("m_pend", 16'(pending), 16'(m_pend));
            chk("m_serv", 16'(in_service), 16'(m_serv));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expects a live request, acks it, eois it, then lets IDLE re-arbitrate.
    task automatic serve(input logic [2:0] id, input logic [15:0] vec);
        chk("srv_req", 16'(int_req), 16'd1);
        chk("srv_id", 16'(int_id), 16'(id));
        chk("srv_vec", int_vector, vec);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        chk("srv_ack_req", 16'(int_req), 16'd0);
        chk("srv_ins", 16'(in_service), 16'(8'd1 << id));
        int_eoi = 1'b1; tick(); int_eoi = 1'b0;
        chk("srv_eoi_ins", 16'(in_service), 16'd0);
        tick();
    endtask

    initial begin
        reset = 1'b1; irq_in = 8'h00; mask_we = 1'b0;
        mask_in = 8'h00; int_ack = 1'b0; int_eoi = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_req", 16'(int_req), 16'd0);
        chk("rst_id", 16'(int_id), 16'd0);
        chk("rst_vec", int_vector, 16'h0100);
        chk("rst_pend", 16'(pending), 16'd0);
        chk("rst_ins", 16'(in_service), 16'd0);
        tick(); tick();

        irq_in = 8'h04; tick(); irq_in = 8'h00;
        chk("single_pend", 16'(pending), 16'h04);
        chk("single_noreq", 16'(int_req), 16'd0);
        tick();
        chk("single_ack_pend_pre", 16'(pending), 16'h04);
        serve(3'd2, 16'h0108);
        chk("single_pend_clr", 16'(pending), 16'h00);

        irq_in = 8'h94; tick(); irq_in = 8'h00; tick();
        serve(3'd7, 16'h011C);
        serve(3'd4, 16'h0110);
        chk("sim_id2", 16'(int_id), 16'd2);
        chk("sim_vec2", int_vector, 16'h0108);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        irq_in = 8'hA2; tick(); irq_in = 8'h00;
        chk("svc_pend", 16'(pending), 16'hA2);
        chk("svc_noreq", 16'(int_req), 16'd0);
        int_eoi = 1'b1; tick(); int_eoi = 1'b0; tick();
        serve(3'd7, 16'h011C);
        serve(3'd5, 16'h0114);
        serve(3'd1, 16'h0104);
        chk("svc_drained", 16'(pending), 16'h00);

        mask_we = 1'b1; mask_in = 8'h7F; tick(); mask_we = 1'b0;
        irq_in = 8'h80; tick(); irq_in = 8'h00; tick(); tick();
        chk("mask_pend", 16'(pending), 16'h80);
        chk("mask_noreq", 16'(int_req), 16'd0);
        mask_we = 1'b1; mask_in = 8'hFF; tick(); mask_we = 1'b0;
        chk("unmask_edge", 16'(int_req), 16'd0);
        tick();
        serve(3'd7, 16'h011C);

        irq_in = 8'h08; tick(); tick();
        serve(3'd3, 16'h010C);
        tick(); tick(); tick(); tick(); tick();
        chk("held_noreq", 16'(int_req), 16'd0);
        chk("held_pend", 16'(pending), 16'h00);
        irq_in = 8'h00; tick();

        irq_in = 8'h08; tick(); irq_in = 8'h00; tick();
        chk("rerise_req", 16'(int_req), 16'd1);
        int_ack = 1'b1; irq_in = 8'h08; tick();
        int_ack = 1'b0; irq_in = 8'h00;
        chk("rerise_pend", 16'(pending), 16'h08);
        chk("rerise_ins", 16'(in_service), 16'h08);
        int_eoi = 1'b1; tick(); int_eoi = 1'b0; tick();
        serve(3'd3, 16'h010C);

        irq_in = 8'h01; tick(); irq_in = 8'h00; tick();
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        irq_in = 8'h30; tick();
        chk("pre_rst_pend", 16'(pending), 16'h30);
        chk("pre_rst_ins", 16'(in_service), 16'h01);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("mid_rst_pend", 16'(pending), 16'h00);
        chk("mid_rst_ins", 16'(in_service), 16'h00);
        chk("mid_rst_vec", int_vector, 16'h0100);
        tick(); tick(); tick();
        chk("post_rst_noreq", 16'(int_req), 16'd0);
        chk("post_rst_pend", 16'(pending), 16'h00);
        irq_in = 8'h00; tick();

        repeat (3000) begin
            irq_in  = 8'($urandom & $urandom & $urandom);
            int_ack = ($urandom_range(0, 2) == 0);
            int_eoi = ($urandom_range(0, 2) == 0);
            mask_we = ($urandom_range(0, 15) == 0);
            mask_in = 8'($urandom);
            reset   = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0; irq_in = 8'h00; int_ack = 1'b0;
        int_eoi = 1'b0; mask_we = 1'b0;
        tick(); tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
